pwm_bridge_decoder: RTL and testbench



---
 rtl/pwm_bridge_decoder.sv | 74 +++++++
 tb/tb_pwm_bridge_decoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_bridge_decoder.sv
// pwm_bridge_decoder: measures PWM1/PWM2 high times per PWM1 period and rebuilds the signed speed command,
// flagging stalled PWM and shoot-through.
module pwm_bridge_decoder #(
  parameter int TIMEOUT     = 4095,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PWM1,
  input  logic        PWM2,
  input  logic        clr_flt,
  output logic [11:0] spd_meas,
  output logic [11:0] period,
  output logic        meas_vld,
  output logic        stalled,
  output logic        shoot_thru
);
  localparam logic [1:0] SEEK  = 2'd0;
  localparam logic [1:0] MEAS  = 2'd1;
  localparam logic [1:0] STALL = 2'd2;
  localparam logic [11:0] TO = 12'(TIMEOUT);
  logic [SYNC_STAGES-1:0] s1, s2;
  logic p1, p2, p1d, rise1;
  logic [1:0] state;
  logic [11:0] per_cnt, h1_cnt, h2_cnt, sat_diff, stall_spd;
  logic signed [12:0] diff;
  assign p1 = s1[SYNC_STAGES-1];
  assign p2 = s2[SYNC_STAGES-1];
  assign rise1 = p1 & ~p1d;
  assign stalled = state == STALL;
  // Dead time idles both legs, so it drops out of the high-time difference.
  assign diff = $signed({1'b0, h1_cnt}) - $signed({1'b0, h2_cnt});
  assign sat_diff = diff > 13'sd2047 ? 12'h7ff : diff < -13'sd2048 ? 12'h800 : diff[11:0];
  assign stall_spd = (p1 & ~p2) ? 12'h7ff : (~p1 & p2) ? 12'h800 : 12'h000;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      p1d <= 1'b0;
      state <= SEEK;
      per_cnt <= '0;
      h1_cnt <= '0;
      h2_cnt <= '0;
      spd_meas <= '0;
      period <= '0;
      meas_vld <= 1'b0;
      shoot_thru <= 1'b0;
    end else begin
      s1 <= {s1[SYNC_STAGES-2:0], PWM1};
      s2 <= {s2[SYNC_STAGES-2:0], PWM2};
      p1d <= p1;
      shoot_thru <= (p1 & p2) | (shoot_thru & ~clr_flt);
      meas_vld <= 1'b0;
      if (rise1) begin
        state <= MEAS;
        per_cnt <= 12'd1;
        h1_cnt <= 12'd1;
        h2_cnt <= 12'd0;
        if (state == MEAS) begin
          period <= per_cnt;
          spd_meas <= sat_diff;
          meas_vld <= 1'b1;
        end
      end else if (state == MEAS) begin
        per_cnt <= per_cnt + {11'd0, per_cnt != 12'hfff};
        h1_cnt <= h1_cnt + {11'd0, p1 && h1_cnt != 12'hfff};
        h2_cnt <= h2_cnt + {11'd0, p2 && h2_cnt != 12'hfff};
        if (per_cnt >= TO) state <= STALL;
      end else if (state == STALL) begin
        spd_meas <= stall_spd;
      end
    end
  end
endmodule

// File: tb/tb_pwm_bridge_decoder.sv
// tb_pwm_bridge_decoder: directed scenarios with hand-computed expectations for pwm_bridge_decoder.
module tb_pwm_bridge_decoder;
  localparam int TIMEOUT = 4095;
  localparam int SYNC = 2;
  logic clk = 0, rst_n = 0, PWM1 = 0, PWM2 = 0, clr_flt = 0;
  logic [11:0] spd_meas, period;
  logic meas_vld, stalled, shoot_thru;
  int total = 0, bad = 0, cyc = 0, vld_cnt = 0, last_rise_cyc = 0, stall_cyc = -1;
  logic stl_q = 0;

  pwm_bridge_decoder #(.TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .PWM1(PWM1), .PWM2(PWM2), .clr_flt(clr_flt),
    .spd_meas(spd_meas), .period(period), .meas_vld(meas_vld),
    .stalled(stalled), .shoot_thru(shoot_thru)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (meas_vld) vld_cnt = vld_cnt + 1;
    if (stalled && !stl_q) stall_cyc = cyc;
    stl_q = stalled;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pwm_period(input int h1, input int d1, input int h2, input int d2);
    PWM1 = 1; last_rise_cyc = cyc; tick(h1);
    PWM1 = 0; tick(d1);
    PWM2 = 1; tick(h2);
    PWM2 = 0; tick(d2);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    PWM1 = 0; PWM2 = 0; rst_n = 0;
    tick(3);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    chk("rst_spd", spd_meas, 0);
    chk("rst_period", period, 0);
    chk("rst_vld", meas_vld, 0);
    chk("rst_stalled", stalled, 0);
    chk("rst_shoot", shoot_thru, 0);
  endtask

  task automatic test_forward();
    int v0;
    v0 = vld_cnt;
    pwm_period(1530, 6, 506, 6);
    chk("fwd_first_no_vld", vld_cnt - v0, 0);
    pwm_period(1530, 6, 506, 6);
    chk("fwd_vld", vld_cnt - v0, 1);
    chk("fwd_spd", spd_meas, 12'h400);
    chk("fwd_period", period, 2048);
  endtask

  task automatic test_reverse();
    int v0;
    do_reset();
    v0 = vld_cnt;
    pwm_period(250, 6, 1786, 6);
    chk("rev_first_no_vld", vld_cnt - v0, 0);
    pwm_period(250, 6, 1786, 6);
    chk("rev_vld", vld_cnt - v0, 1);
    chk("rev_spd", spd_meas, 12'ha00);
    chk("rev_period", period, 2048);
  endtask

  task automatic test_stall_idle();
    int v0;
    pwm_period(1530, 6, 506, 6);
    stall_cyc = -1;
    v0 = vld_cnt;
    tick(5000);
    chk("idle_stalled", stalled, 1);
    chk("idle_stall_delay", stall_cyc - last_rise_cyc, TIMEOUT + SYNC + 1);
    chk("idle_spd", spd_meas, 0);
    chk("idle_no_vld", vld_cnt - v0, 0);
    pwm_period(1530, 6, 506, 6);
    chk("resume_unstalled", stalled, 0);
    chk("resume_no_vld", vld_cnt - v0, 0);
    pwm_period(1530, 6, 506, 6);
    chk("resume_vld", vld_cnt - v0, 1);
    chk("resume_spd", spd_meas, 12'h400);
  endtask

  task automatic test_stuck();
    PWM1 = 1; PWM2 = 0;
    tick(5000);
    chk("stuck1_stalled", stalled, 1);
    chk("stuck1_spd", spd_meas, 12'h7ff);
    PWM1 = 0; PWM2 = 1;
    tick(20);
    chk("stuck2_stalled", stalled, 1);
    chk("stuck2_spd", spd_meas, 12'h800);
    PWM2 = 0;
    tick(10);
    chk("stuck_idle_spd", spd_meas, 0);
  endtask

  task automatic test_saturation();
    int v0;
    v0 = vld_cnt;
    pwm_period(3000, 5, 0, 5);
    chk("sat_start_no_vld", vld_cnt - v0, 0);
    pwm_period(1, 4, 3000, 5);
    chk("sat_pos_spd", spd_meas, 12'h7ff);
    chk("sat_pos_period", period, 3010);
    pwm_period(1530, 6, 506, 6);
    chk("sat_neg_spd", spd_meas, 12'h800);
    chk("sat_neg_period", period, 3010);
    chk("sat_vld", vld_cnt - v0, 2);
  endtask

  task automatic test_shoot_thru();
    PWM1 = 1; PWM2 = 1; tick(1);
    PWM1 = 0; PWM2 = 0; tick(5);
    chk("shoot_set", shoot_thru, 1);
    tick(20);
    chk("shoot_sticky", shoot_thru, 1);
    clr_flt = 1; tick(1);
    clr_flt = 0; tick(2);
    chk("shoot_clear", shoot_thru, 0);
    PWM1 = 1; PWM2 = 1; tick(1);
    PWM1 = 0; PWM2 = 0; tick(SYNC - 1);
    clr_flt = 1; tick(1);
    clr_flt = 0; tick(3);
    chk("shoot_set_wins", shoot_thru, 1);
  endtask

  task automatic test_mid_reset();
    int v0;
    pwm_period(1530, 6, 506, 6);
    pwm_period(1530, 6, 506, 6);
    PWM1 = 1; tick(700);
    rst_n = 0; tick(1);
    rst_n = 1;
    @(negedge clk);
    chk("mrst_spd", spd_meas, 0);
    chk("mrst_period", period, 0);
    chk("mrst_stalled", stalled, 0);
    chk("mrst_shoot", shoot_thru, 0);
    chk("mrst_vld", meas_vld, 0);
    PWM1 = 0; tick(10);
    v0 = vld_cnt;
    pwm_period(250, 6, 1786, 6);
    chk("mrst_first_no_vld", vld_cnt - v0, 0);
    pwm_period(250, 6, 1786, 6);
    chk("mrst_vld", vld_cnt - v0, 1);
    chk("mrst_spd_after", spd_meas, 12'ha00);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_stall_idle();
    test_stuck();
    test_saturation();
    test_shoot_thru();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
